// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan driver.
// Segment patterns are stored in active-low form, bits {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_BLANK_N = 7'h7F;

  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    return SEG_TBL[nibble];
  endfunction

  // Counter width that stays legal when the range collapses to a single value.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot counter and digit index for the multiplexed scan; held cleared while en is low.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = 10,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned GUARD_CYCLES = 2,
  localparam int unsigned CW = width_of(SLOT_CYCLES),
  localparam int unsigned IW = width_of(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] slot_cnt,
  output logic [IW-1:0] idx,
  output logic          guard,
  output logic          slot_wrap,
  output logic          frame_wrap
);

  always_comb begin
    guard      = slot_cnt < CW'(GUARD_CYCLES);
    slot_wrap  = en && (slot_cnt == CW'(SLOT_CYCLES - 1));
    frame_wrap = slot_wrap && (idx == IW'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (!en) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      idx      <= frame_wrap ? '0 : idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a frame-synchronous
// double-buffered display image, leading-zero blanking and per-slot guard time.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned GUARD_CYCLES = 64,
  parameter bit          SEG_ACT_LOW  = 1'b1,
  parameter bit          DIG_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame_tick
);

  localparam int unsigned SLOT_CYCLES = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int unsigned CW = width_of(SLOT_CYCLES);
  localparam int unsigned IW = width_of(NUM_DIGITS);

  localparam logic [7:0]            SEG_OFF = SEG_ACT_LOW ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACT_LOW ? '1 : '0;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_driver: NUM_DIGITS must be 1..8");
  end
  if (SLOT_CYCLES <= GUARD_CYCLES) begin : g_bad_guard
    $error("seg7_scan_driver: SLOT_CYCLES must exceed GUARD_CYCLES");
  end

  logic [CW-1:0] slot_cnt;
  logic [IW-1:0] idx;
  logic          guard;
  logic          slot_wrap;
  logic          frame_wrap;

  seg7_scan_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .NUM_DIGITS   (NUM_DIGITS),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .slot_cnt   (slot_cnt),
    .idx        (idx),
    .guard      (guard),
    .slot_wrap  (slot_wrap),
    .frame_wrap (frame_wrap)
  );

  // Raw slot position is only needed inside the timer.
  logic unused_timer;
  assign unused_timer = ^{slot_cnt, slot_wrap};

  logic [4*NUM_DIGITS-1:0] act_val;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_vld;

  // A load coinciding with the frame boundary goes straight to the active image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_val  <= '0;
      act_dp   <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      pend_vld <= 1'b0;
    end else if (load && frame_wrap) begin
      act_val  <= value;
      act_dp   <= dp_in;
      pend_vld <= 1'b0;
    end else begin
      if (frame_wrap && pend_vld) begin
        act_val  <= pend_val;
        act_dp   <= pend_dp;
        pend_vld <= 1'b0;
      end
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pend_vld <= 1'b1;
      end
    end
  end

  logic [NUM_DIGITS-1:0] blank;
  logic                  lead;
  logic [NUM_DIGITS-1:0] dig_hi;
  logic [3:0]            cur_nib;
  logic [7:0]            seg_low;

  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i > 0; i--) begin
      lead     = lead && (act_val[4*i +: 4] == 4'h0);
      blank[i] = lz_blank && lead;
    end
  end

  always_comb begin
    dig_hi = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dig_hi[i] = en && !guard && (idx == IW'(i));
    end
    cur_nib = act_val[{idx, 2'b00} +: 4];
    seg_low = {~act_dp[idx], blank[idx] ? SEG_BLANK_N : hex2seg(cur_nib)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      dig        <= DIG_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= SEG_ACT_LOW ? seg_low : ~seg_low;
      dig        <= DIG_ACT_LOW ? ~dig_hi : dig_hi;
      frame_tick <= frame_wrap;
    end
  end

endmodule
